// File: rtl/sm4_iter_core.sv
// rtl/sm4_iter_core.sv - Iterative SM4 engine with on-chip key expansion, UNROLL rounds per clock
module sm4_iter_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         key_ok,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sm4_iter_core: UNROLL must be 1, 2, 4 or 8");
    end

    localparam int NCYC = 32 / UNROLL;
    localparam int RW   = $clog2(NCYC);
    localparam int CW   = RW + 1;
    localparam logic [CW-1:0] LAST   = CW'(NCYC - 1);
    localparam logic [RW-1:0] LAST_R = RW'(NCYC - 1);

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_READY,
        S_CRYPT,
        S_DONE
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    // Data-path round transform: tau then L
    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    // Key-schedule transform: tau then L'
    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    // CK_i: byte j (MSB first) is (4i+j)*7 mod 256
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[31 - 8 * j -: 8] = 8'((4 * int'(i) + j) * 7);
        end
        return r;
    endfunction

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [RW-1:0]          row;
    logic [127:0]           kreg;
    logic [127:0]           xreg;
    logic                   mode;

    // Round keys stored as one row of UNROLL words per key-expansion cycle,
    // word j of row r holding rk[r*UNROLL + j].
    logic [32*UNROLL-1:0]   rk_row [NCYC];
    logic [32*UNROLL-1:0]   rk_wrow;
    logic [32*UNROLL-1:0]   rk_rrow;

    logic [31:0]            kw [UNROLL+4];
    logic [31:0]            xw [UNROLL+4];

    assign row       = cnt[RW-1:0];
    assign key_ready = (state == S_IDLE) || (state == S_READY);
    assign key_ok    = (state == S_READY) || (state == S_CRYPT) || (state == S_DONE);
    // A simultaneous key request takes priority over a block in READY
    assign in_ready  = (state == S_READY) && !key_valid;
    assign out_valid = (state == S_DONE);

    // Decrypt walks the store backwards: last row first, words high to low
    assign rk_rrow = rk_row[mode ? (LAST_R - row) : row];

    // Unrolled key-schedule and cipher rounds for the current cycle
    always_comb begin
        for (int j = 0; j < UNROLL + 4; j++) begin
            kw[j] = '0;
            xw[j] = '0;
        end
        rk_wrow = '0;
        for (int j = 0; j < 4; j++) begin
            kw[j] = kreg[127 - 32 * j -: 32];
            xw[j] = xreg[127 - 32 * j -: 32];
        end
        for (int j = 0; j < UNROLL; j++) begin
            kw[j+4] = kw[j] ^ t_key(kw[j+1] ^ kw[j+2] ^ kw[j+3]
                                    ^ ck(5'(int'(cnt) * UNROLL + j)));
            rk_wrow[32 * j +: 32] = kw[j+4];
            if (mode) begin
                xw[j+4] = xw[j] ^ t_enc(xw[j+1] ^ xw[j+2] ^ xw[j+3]
                                        ^ rk_rrow[32 * (UNROLL - 1 - j) +: 32]);
            end else begin
                xw[j+4] = xw[j] ^ t_enc(xw[j+1] ^ xw[j+2] ^ xw[j+3]
                                        ^ rk_rrow[32 * j +: 32]);
            end
        end
    end

    // Round-key store write; contents are meaningless until key_ok rises
    always_ff @(posedge clk) begin
        if (state == S_KEYEXP) begin
            rk_row[row] <= rk_wrow;
        end
    end

    // Control FSM with key and data working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kreg     <= '0;
            xreg     <= '0;
            mode     <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_valid) begin
                        kreg  <= key_in ^ FK;
                        cnt   <= '0;
                        state <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    kreg <= {kw[UNROLL], kw[UNROLL+1], kw[UNROLL+2], kw[UNROLL+3]};
                    if (cnt == LAST) begin
                        state <= S_READY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_READY: begin
                    if (key_valid) begin
                        kreg  <= key_in ^ FK;
                        cnt   <= '0;
                        state <= S_KEYEXP;
                    end else if (in_valid) begin
                        xreg  <= in_data;
                        mode  <= in_mode;
                        cnt   <= '0;
                        state <= S_CRYPT;
                    end
                end
                S_CRYPT: begin
                    xreg <= {xw[UNROLL], xw[UNROLL+1], xw[UNROLL+2], xw[UNROLL+3]};
                    if (cnt == LAST) begin
                        out_data <= {xw[UNROLL+3], xw[UNROLL+2], xw[UNROLL+1], xw[UNROLL]};
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_READY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_iter_core.sv
// tb/tb_sm4_iter_core.sv - Randomized self-checking bench for sm4_iter_core at UNROLL 1, 2, 4, 8
module tb_sm4_iter_core;

    localparam logic [127:0] KAT_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   key_valid;
    logic [3:0]   in_valid;
    logic [3:0]   out_ready;
    logic         in_mode;
    logic [127:0] key_in;
    logic [127:0] in_data;
    logic [3:0]   key_ready;
    logic [3:0]   key_ok;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [127:0] out_data [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sm4_iter_core #(.UNROLL(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_valid (key_valid[g]),
            .key_ready (key_ready[g]),
            .key_in    (key_in),
            .key_ok    (key_ok[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_mode   (in_mode),
            .in_data   (in_data),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int u, input string s);
        return $sformatf("u%0d_%s", 1 << u, s);
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] a, input int n);
        logic [63:0] d;
        d = {a, a};
        return d[63 - n -: 32];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8 * i +: 8] = SBOX[2047 - 8 * int'(a[8 * i +: 8]) -: 8];
        end
        return r;
    endfunction

    // Straight textbook SM4: full 32-entry key schedule, then 32 rounds
    function automatic logic [127:0] sm4_ref(input logic [127:0] key, input logic [127:0] blk,
                                             input logic dec);
        logic [31:0] fk [4];
        logic [31:0] k [36];
        logic [31:0] x [36];
        logic [31:0] rk [32];
        logic [31:0] ckw;
        logic [31:0] b;
        fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
        for (int i = 0; i < 4; i++) begin
            k[i] = key[127 - 32 * i -: 32] ^ fk[i];
            x[i] = blk[127 - 32 * i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ckw[31 - 8 * j -: 8] = 8'(((4 * i + j) * 7) % 256);
            b = sub_word(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckw);
            k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
            rk[i] = k[i+4];
        end
        for (int i = 0; i < 32; i++) begin
            b = sub_word(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[dec ? 31 - i : i]);
            x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_key(input int u, input logic [127:0] key);
        int lat;
        lat = 0;
        while (!key_ready[u] && lat < 200) begin @(posedge clk); #1; lat++; end
        key_in = key;
        key_valid[u] = 1'b1;
        @(posedge clk); #1;
        key_valid[u] = 1'b0;
        check(tg(u, "key_ok_low"), 128'(key_ok[u]), 128'(0));
        check(tg(u, "key_ready_busy"), 128'(key_ready[u]), 128'(0));
        lat = 0;
        while (!key_ok[u] && lat < 200) begin @(posedge clk); #1; lat++; end
        check(tg(u, "key_lat"), 128'(lat), 128'(32 >> u));
    endtask

    task automatic run_block(input int u, input logic [127:0] data, input logic mode,
                             input logic [127:0] exp, input int stall, output logic [127:0] res);
        int lat;
        logic [127:0] held;
        lat = 0;
        while (!in_ready[u] && lat < 200) begin @(posedge clk); #1; lat++; end
        in_data = data;
        in_mode = mode;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        check(tg(u, "crypt_in_ready"), 128'(in_ready[u]), 128'(0));
        lat = 0;
        while (!out_valid[u] && lat < 200) begin @(posedge clk); #1; lat++; end
        check(tg(u, "out_lat"), 128'(lat), 128'(32 >> u));
        check(tg(u, mode ? "dec_data" : "enc_data"), out_data[u], exp);
        held = out_data[u];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check(tg(u, "stall_data"), out_data[u], held);
            check(tg(u, "stall_valid"), 128'(out_valid[u]), 128'(1));
            check(tg(u, "stall_in_ready"), 128'(in_ready[u]), 128'(0));
        end
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        check(tg(u, "post_valid"), 128'(out_valid[u]), 128'(0));
        check(tg(u, "post_in_ready"), 128'(in_ready[u]), 128'(1));
        res = held;
    endtask

    task automatic collide(input int u, input logic [127:0] new_key, input logic [127:0] data);
        int lat;
        key_in = new_key;
        in_data = data;
        in_mode = 1'b0;
        key_valid[u] = 1'b1;
        in_valid[u] = 1'b1;
        #1;
        check(tg(u, "coll_in_ready"), 128'(in_ready[u]), 128'(0));
        check(tg(u, "coll_key_ready"), 128'(key_ready[u]), 128'(1));
        @(posedge clk); #1;
        key_valid[u] = 1'b0;
        check(tg(u, "coll_key_ok"), 128'(key_ok[u]), 128'(0));
        lat = 0;
        while (!key_ok[u] && lat < 200) begin
            check(tg(u, "coll_hold_in_ready"), 128'(in_ready[u]), 128'(0));
            @(posedge clk); #1; lat++;
        end
        check(tg(u, "coll_key_lat"), 128'(lat), 128'(32 >> u));
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        lat = 0;
        while (!out_valid[u] && lat < 200) begin @(posedge clk); #1; lat++; end
        check(tg(u, "coll_out_lat"), 128'(lat), 128'(32 >> u));
        check(tg(u, "coll_data"), out_data[u], sm4_ref(new_key, data, 1'b0));
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
    endtask

    task automatic reset_mid(input int u);
        in_data = rnd128();
        in_mode = 1'b0;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check(tg(u, "rst_out_valid"), 128'(out_valid[u]), 128'(0));
        check(tg(u, "rst_in_ready"), 128'(in_ready[u]), 128'(0));
        check(tg(u, "rst_key_ok"), 128'(key_ok[u]), 128'(0));
        check(tg(u, "rst_key_ready"), 128'(key_ready[u]), 128'(1));
        @(posedge clk); #2;
        rst_n = 1'b1;
        in_valid[u] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check(tg(u, "idle_in_ready"), 128'(in_ready[u]), 128'(0));
            check(tg(u, "idle_out_valid"), 128'(out_valid[u]), 128'(0));
        end
        in_valid[u] = 1'b0;
        check(tg(u, "idle_out_data"), out_data[u], 128'(0));
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] key;
        logic [127:0] d;
        logic         m;
        key_valid = '0;
        in_valid  = '0;
        out_ready = '0;
        in_mode   = 1'b0;
        key_in    = '0;
        in_data   = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int u = 0; u < 4; u++) begin
            check(tg(u, "reset_key_ready"), 128'(key_ready[u]), 128'(1));
            check(tg(u, "reset_key_ok"), 128'(key_ok[u]), 128'(0));
            check(tg(u, "reset_in_ready"), 128'(in_ready[u]), 128'(0));
            check(tg(u, "reset_out_valid"), 128'(out_valid[u]), 128'(0));
            check(tg(u, "reset_out_data"), out_data[u], 128'(0));
        end
        for (int u = 0; u < 4; u++) begin
            load_key(u, KAT_PT);
            run_block(u, KAT_PT, 1'b0, KAT_CT, 0, res);
            run_block(u, KAT_CT, 1'b1, KAT_PT, 10, res);
            d = KAT_PT;
            for (int i = 0; i < 3; i++) begin
                run_block(u, d, 1'b0, sm4_ref(KAT_PT, d, 1'b0), int'($urandom_range(0, 3)), d);
            end
            key = KAT_PT;
            for (int i = 0; i < 6; i++) begin
                if (i % 3 == 0) begin
                    key = rnd128();
                    load_key(u, key);
                end
                d = rnd128();
                m = 1'($urandom_range(0, 1));
                run_block(u, d, m, sm4_ref(key, d, m), int'($urandom_range(0, 3)), res);
            end
            collide(u, rnd128(), rnd128());
            reset_mid(u);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
